// File: rtl/adc_capture_buffer.sv
// Captures DEPTH ADC samples into a local buffer, then replays them oldest-first
// over a divided-clock SCL/SS/MOSI link. Single-shot or continuous bursts.
module adc_capture_buffer #(
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 10,
  parameter int CLK_DIV  = 250
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         mode,
  input  logic                         adc_valid,
  input  logic [SAMPLE_W-1:0]          adc_data,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic [$clog2(DEPTH+1)-1:0]   collected,
  output logic [$clog2(DEPTH+1)-1:0]   transmitted,
  output logic                         SCL,
  output logic                         SS,
  output logic                         MOSI
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(2*CLK_DIV);
  localparam int BW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, LOAD, SHIFT, GAP} state_t;

  state_t                state, state_n;
  logic                  mode_q, mode_n;
  logic [TW-1:0]         tick, tick_n;
  logic [BW-1:0]         fall_cnt, fall_n;
  logic [SAMPLE_W-1:0]   shreg, sh_n, sh_next, rd_word;
  logic [CW-1:0]         coll_n, trans_n;
  logic                  ovr_n, done_n, busy_n, scl_n, ss_n, mosi_n, wr_en;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic [SAMPLE_W-1:0]   mem [0:DEPTH-1];

  assign wr_idx  = AW'(collected);
  assign rd_idx  = AW'(transmitted);
  assign rd_word = mem[rd_idx];
  assign sh_next = shreg << 1;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= adc_data;
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    tick_n  = tick;
    fall_n  = fall_cnt;
    sh_n    = shreg;
    coll_n  = collected;
    trans_n = transmitted;
    ovr_n   = overrun;
    done_n  = 1'b0;
    scl_n   = SCL;
    ss_n    = SS;
    mosi_n  = MOSI;
    wr_en   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      scl_n   = 1'b0;
      ss_n    = 1'b1;
      mosi_n  = 1'b0;
    end else begin
      if (adc_valid && (state == LOAD || state == SHIFT || state == GAP)) ovr_n = 1'b1;
      unique case (state)
        IDLE: if (start) begin
          mode_n  = mode;
          coll_n  = '0;
          trans_n = '0;
          ovr_n   = 1'b0;
          state_n = CAPTURE;
        end
        CAPTURE: if (adc_valid) begin
          wr_en  = 1'b1;
          coll_n = collected + CW'(1);
          if (coll_n == CW'(DEPTH)) state_n = LOAD;
        end
        LOAD: begin
          sh_n    = rd_word;
          ss_n    = 1'b0;
          mosi_n  = rd_word[SAMPLE_W-1];
          scl_n   = 1'b0;
          tick_n  = '0;
          fall_n  = '0;
          state_n = SHIFT;
        end
        SHIFT: if (tick == TW'(CLK_DIV-1)) begin
          tick_n = '0;
          scl_n  = ~SCL;
          // Falling edge: advance to the next bit, or close the word after the last one.
          if (SCL) begin
            if (fall_cnt == BW'(SAMPLE_W-1)) begin
              ss_n    = 1'b1;
              mosi_n  = 1'b0;
              trans_n = transmitted + CW'(1);
              state_n = GAP;
            end else begin
              sh_n   = sh_next;
              mosi_n = sh_next[SAMPLE_W-1];
              fall_n = fall_cnt + BW'(1);
            end
          end
        end else begin
          tick_n = tick + TW'(1);
        end
        GAP: if (tick == TW'(2*CLK_DIV-1)) begin
          tick_n = '0;
          if (transmitted < CW'(DEPTH)) begin
            state_n = LOAD;
          end else begin
            done_n = 1'b1;
            if (mode_q) begin
              state_n = CAPTURE;
              coll_n  = '0;
              trans_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          tick_n = tick + TW'(1);
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      tick        <= '0;
      fall_cnt    <= '0;
      shreg       <= '0;
      collected   <= '0;
      transmitted <= '0;
      overrun     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      SCL         <= 1'b0;
      SS          <= 1'b1;
      MOSI        <= 1'b0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      tick        <= tick_n;
      fall_cnt    <= fall_n;
      shreg       <= sh_n;
      collected   <= coll_n;
      transmitted <= trans_n;
      overrun     <= ovr_n;
      done        <= done_n;
      busy        <= busy_n;
      SCL         <= scl_n;
      SS          <= ss_n;
      MOSI        <= mosi_n;
    end
  end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer: a small 4/3/2 instance driven by a vector table and
// random bursts, plus a default-parameter instance streaming ten words concurrently.
module tb_adc_capture_buffer;
  localparam int W        = 4;
  localparam int D        = 3;
  localparam int CD       = 2;
  localparam int CNTW     = $clog2(D+1);
  localparam int SS_LOW   = 2*CD*W;
  localparam int PERIOD   = 2*CD*(W+1)+1;
  localparam int BW       = 12;
  localparam int BD       = 10;
  localparam int BCD      = 250;
  localparam int BCNTW    = $clog2(BD+1);
  localparam int B_SS_LOW = 2*BCD*BW;
  localparam int B_PERIOD = 2*BCD*(BW+1)+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_start, a_abort, a_mode, a_valid;
  logic [W-1:0] a_data;
  logic a_busy, a_done, a_ovr, a_scl, a_ss, a_mosi;
  logic [CNTW-1:0] a_coll, a_trans;

  logic b_rst, b_start, b_abort, b_mode, b_valid;
  logic [BW-1:0] b_data;
  logic b_busy, b_done, b_ovr, b_scl, b_ss, b_mosi;
  logic [BCNTW-1:0] b_coll, b_trans;

  adc_capture_buffer #(.SAMPLE_W(W), .DEPTH(D), .CLK_DIV(CD)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort), .mode(a_mode),
    .adc_valid(a_valid), .adc_data(a_data), .busy(a_busy), .done(a_done),
    .overrun(a_ovr), .collected(a_coll), .transmitted(a_trans),
    .SCL(a_scl), .SS(a_ss), .MOSI(a_mosi));

  adc_capture_buffer dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort), .mode(b_mode),
    .adc_valid(b_valid), .adc_data(b_data), .busy(b_busy), .done(b_done),
    .overrun(b_ovr), .collected(b_coll), .transmitted(b_trans),
    .SCL(b_scl), .SS(b_ss), .MOSI(b_mosi));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial decoder for instance A: one record per SS-low window.
  typedef struct {
    logic [W-1:0] w;
    int len;
    int nb;
    int r1;
    int fall;
    bit stab;
  } rec_t;
  rec_t a_q[$];
  int a_falls  = 0;
  int a_done_n = 0;

  initial begin
    logic pscl, pss, pmosi;
    logic [W-1:0] sh;
    int cyc, nb, fall, r1;
    bit stab;
    pscl = 1'b0; pss = 1'b1; pmosi = 1'b0; sh = '0;
    cyc = 0; nb = 0; fall = 0; r1 = 0; stab = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (a_done === 1'b1) a_done_n++;
      if (pss && !a_ss) begin
        fall = cyc; nb = 0; sh = '0; stab = 1'b1; r1 = -1; a_falls++;
      end
      if (!pss && !a_ss && a_mosi !== pmosi && !(pscl && !a_scl)) stab = 1'b0;
      if (!pscl && a_scl && !a_ss) begin
        if (nb == 0) r1 = cyc - fall;
        sh = {sh[W-2:0], a_mosi};
        nb++;
      end
      if (!pss && a_ss)
        a_q.push_back('{w: sh, len: cyc - fall, nb: nb, r1: r1, fall: fall, stab: stab});
      pscl = a_scl; pss = a_ss; pmosi = a_mosi;
    end
  end

  // Serial decoder for the default instance.
  typedef struct {
    logic [BW-1:0] w;
    int len;
    int fall;
  } brec_t;
  brec_t b_q[$];
  int b_scl_per = 0;
  bit b_fin = 1'b0;

  initial begin
    logic pscl, pss;
    logic [BW-1:0] sh;
    int cyc, fall, lrise;
    pscl = 1'b0; pss = 1'b1; sh = '0; cyc = 0; fall = 0; lrise = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (pss && !b_ss) begin fall = cyc; sh = '0; lrise = -1; end
      if (!pscl && b_scl && !b_ss) begin
        if (lrise >= 0 && b_scl_per == 0) b_scl_per = cyc - lrise;
        lrise = cyc;
        sh = {sh[BW-2:0], b_mosi};
      end
      if (!pss && b_ss) b_q.push_back('{w: sh, len: cyc - fall, fall: fall});
      pscl = b_scl; pss = b_ss;
    end
  end

  typedef struct packed {
    logic [D-1:0][W-1:0] s;
    logic                inj;
    logic [D-1:0][W-1:0] e;
    logic                e_ovr;
  } vec_t;

  function automatic vec_t mk(input logic [W-1:0] s0, s1, s2, input logic inj,
                              input logic [W-1:0] e0, e1, e2, input logic eo);
    vec_t v;
    v.s = {s2, s1, s0}; v.inj = inj; v.e = {e2, e1, e0}; v.e_ovr = eo;
    return v;
  endfunction

  task automatic send(input logic [W-1:0] v);
    a_valid = 1'b1; a_data = v;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (a_done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    check({tag, ".done_seen"}, a_done, 1);
  endtask

  task automatic check_words(input logic [W-1:0] exq [$], input string tag);
    check({tag, ".nwords"}, a_q.size(), exq.size());
    for (int i = 0; i < a_q.size() && i < exq.size(); i++) begin
      check($sformatf("%s.w%0d", tag, i), a_q[i].w, exq[i]);
      check($sformatf("%s.len%0d", tag, i), a_q[i].len, SS_LOW);
      check($sformatf("%s.bits%0d", tag, i), a_q[i].nb, W);
      check($sformatf("%s.rise1_%0d", tag, i), a_q[i].r1, CD);
      check($sformatf("%s.stable%0d", tag, i), a_q[i].stab, 1);
      if (i % D != 0)
        check($sformatf("%s.period%0d", tag, i), a_q[i].fall - a_q[i-1].fall, PERIOD);
    end
  endtask

  task automatic run_burst(input logic [D-1:0][W-1:0] smp, input logic inj,
                           input logic [D-1:0][W-1:0] ex, input logic eo, input string tag);
    int base_done, base_f, n;
    logic [W-1:0] exq [$];
    a_q.delete();
    base_done = a_done_n; base_f = a_falls;
    a_mode = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check({tag, ".busy_start"}, a_busy, 1);
    check({tag, ".ovr_cleared"}, a_ovr, 0);
    check({tag, ".coll_cleared"}, a_coll, 0);
    for (int i = 0; i < D; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(smp[i]);
    end
    check({tag, ".coll_full"}, a_coll, D);
    check({tag, ".ss_load"}, a_ss, 1);
    @(negedge clk);
    check({tag, ".ss_fall"}, a_ss, 0);
    if (inj) begin
      n = 0;
      while (a_falls < base_f + 2 && n < 100) begin @(negedge clk); n++; end
      repeat ($urandom_range(1, 8)) @(negedge clk);
      send(W'($urandom));
    end
    wait_done(tag, 200);
    check({tag, ".busy_end"}, a_busy, 0);
    @(negedge clk);
    check({tag, ".done_width"}, a_done, 0);
    check({tag, ".done_cnt"}, a_done_n - base_done, 1);
    check({tag, ".coll_end"}, a_coll, D);
    check({tag, ".trans_end"}, a_trans, D);
    check({tag, ".ovr"}, a_ovr, eo);
    for (int i = 0; i < D; i++) exq.push_back(ex[i]);
    check_words(exq, tag);
  endtask

  // Reference model: words leave in the order they were captured.
  logic [W-1:0] mdl [$];

  task automatic rand_burst(input string tag, input logic inj);
    logic [D-1:0][W-1:0] smp, ex;
    for (int i = 0; i < D; i++) begin smp[i] = W'($urandom); mdl.push_back(smp[i]); end
    for (int i = 0; i < D; i++) ex[i] = mdl.pop_front();
    run_burst(smp, inj, ex, inj, tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".busy"}, a_busy, 0);
    check({tag, ".done"}, a_done, 0);
    check({tag, ".ovr"}, a_ovr, 0);
    check({tag, ".coll"}, a_coll, 0);
    check({tag, ".trans"}, a_trans, 0);
    check({tag, ".scl"}, a_scl, 0);
    check({tag, ".ss"}, a_ss, 1);
    check({tag, ".mosi"}, a_mosi, 0);
  endtask

  initial begin
    vec_t tbl [4];
    logic [W-1:0] exq [$];
    logic [W-1:0] v;
    int base_done, base_f, n;
    bit seen;
    tbl[0] = mk(4'hA, 4'h3, 4'hF, 1'b0, 4'hA, 4'h3, 4'hF, 1'b0);
    tbl[1] = mk(4'hA, 4'h3, 4'hF, 1'b1, 4'hA, 4'h3, 4'hF, 1'b1);
    tbl[2] = mk(4'h0, 4'h8, 4'h1, 1'b0, 4'h0, 4'h8, 4'h1, 1'b0);
    tbl[3] = mk(4'h5, 4'hC, 4'h7, 1'b1, 4'h5, 4'hC, 4'h7, 1'b1);

    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_mode = 1'b0; a_valid = 1'b0; a_data = '0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    a_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_burst(tbl[i].s, tbl[i].inj, tbl[i].e, tbl[i].e_ovr, $sformatf("vec%0d", i));
    for (int k = 0; k < 4; k++)
      rand_burst($sformatf("rnd%0d", k), logic'($urandom_range(0, 1)));

    // Continuous mode: two bursts back to back, mode latched only with start.
    a_q.delete(); base_done = a_done_n;
    a_mode = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_mode = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < D; i++) begin v = W'($urandom); exq.push_back(v); send(v); end
      wait_done($sformatf("m1.b%0d", k), 200);
      check($sformatf("m1.b%0d.busy", k), a_busy, 1);
      check($sformatf("m1.b%0d.coll", k), a_coll, 0);
      check($sformatf("m1.b%0d.trans", k), a_trans, 0);
    end
    @(negedge clk);
    check("m1.done_cnt", a_done_n - base_done, 2);
    check("m1.ovr", a_ovr, 0);
    check_words(exq, "m1");
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("m1.abort_busy", a_busy, 0);

    // Abort in the middle of word 2.
    base_done = a_done_n; base_f = a_falls;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < D; i++) send(W'($urandom));
    n = 0;
    while (a_falls < base_f + 2 && n < 100) begin @(negedge clk); n++; end
    check("ab.reach_w2", a_falls >= base_f + 2, 1);
    repeat (5) @(negedge clk);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("ab.ss", a_ss, 1);
    check("ab.scl", a_scl, 0);
    check("ab.mosi", a_mosi, 0);
    check("ab.busy", a_busy, 0);
    check("ab.trans", a_trans, 1);
    check("ab.coll", a_coll, D);
    seen = 1'b0;
    repeat (60) begin @(negedge clk); if (a_done === 1'b1) seen = 1'b1; end
    check("ab.no_done", seen, 0);
    check("ab.done_cnt", a_done_n - base_done, 0);
    rand_burst("post_abort", 1'b0);

    // Start while capturing is ignored; reset mid-capture is immediate.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    send(W'($urandom));
    a_mode = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_mode = 1'b0;
    check("rst.start_ignored", a_coll, 1);
    check("rst.busy_kept", a_busy, 1);
    send(W'($urandom));
    check("rst.coll2", a_coll, 2);
    a_rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    rand_burst("post_rst", 1'b1);

    n = 0;
    while (!b_fin && n < 80000) begin @(negedge clk); n++; end
    check("def.finished", b_fin, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Default parameters: ten samples 0..9 streamed single-shot.
  initial begin
    int n;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_mode = 1'b0; b_valid = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < BD; i++) begin b_valid = 1'b1; b_data = BW'(i); @(negedge clk); end
    b_valid = 1'b0;
    n = 0;
    while (b_done !== 1'b1 && n < 70000) begin @(negedge clk); n++; end
    check("def.done_seen", b_done, 1);
    check("def.busy_end", b_busy, 0);
    check("def.ovr", b_ovr, 0);
    check("def.coll", b_coll, BD);
    check("def.trans", b_trans, BD);
    @(negedge clk);
    check("def.scl_period", b_scl_per, 2*BCD);
    check("def.nwords", b_q.size(), BD);
    for (int i = 0; i < b_q.size() && i < BD; i++) begin
      check($sformatf("def.w%0d", i), b_q[i].w, i);
      check($sformatf("def.len%0d", i), b_q[i].len, B_SS_LOW);
      if (i > 0) check($sformatf("def.period%0d", i), b_q[i].fall - b_q[i-1].fall, B_PERIOD);
    end
    b_fin = 1'b1;
  end
endmodule
